// File: rtl/ldpc_mux_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ldpc_mux_scheduler_if : descriptor / data / forest-side bus bundle        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface ldpc_mux_scheduler_if #(
  parameter int WIDTH            = 8,
  parameter int NUM_RAMS         = 24,
  parameter int EXPANSION_FACTOR = 96
);
  localparam int OW = $clog2(EXPANSION_FACTOR);
  localparam int RW = $clog2(NUM_RAMS);

  logic [8*OW-1:0]    i_desc_shift;
  logic [8*RW-1:0]    i_desc_ram;
  logic [8*3-1:0]     i_desc_branch;
  logic               i_desc_valid;
  logic               o_desc_ready;
  logic [8*WIDTH-1:0] i_data;
  logic               i_data_valid;
  logic               o_data_ready;
  logic [8*WIDTH-1:0] o_data;
  logic [8*OW-1:0]    o_offset;
  logic [8*RW-1:0]    o_ram_addr;
  logic [8*3-1:0]     o_to_branch;
  logic               o_valid;
  logic               o_busy;
  logic               o_done;
  logic               o_desc_error;

  modport master (
    output i_desc_shift, i_desc_ram, i_desc_branch, i_desc_valid, i_data, i_data_valid,
    input  o_desc_ready, o_data_ready, o_data, o_offset, o_ram_addr, o_to_branch,
           o_valid, o_busy, o_done, o_desc_error
  );

  modport slave (
    input  i_desc_shift, i_desc_ram, i_desc_branch, i_desc_valid, i_data, i_data_valid,
    output o_desc_ready, o_data_ready, o_data, o_offset, o_ram_addr, o_to_branch,
           o_valid, o_busy, o_done, o_desc_error
  );
endinterface
`default_nettype wire

// File: rtl/ldpc_mux_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ldpc_mux_scheduler : one-layer sequencer feeding the LDPC mux forest      |
// | Optional stats counters: LDPC_MUX_SCHEDULER_STATS_EN         Rev 1.0     |
// +--------------------------------------------------------------------------+
module ldpc_mux_scheduler #(
  parameter int WIDTH            = 8,
  parameter int NUM_RAMS         = 24,
  parameter int EXPANSION_FACTOR = 96
) (
  input  logic                i_clock,
  input  logic                i_reset,
  ldpc_mux_scheduler_if.slave bus
`ifdef LDPC_MUX_SCHEDULER_STATS_EN
  ,
  output logic [15:0]         o_layer_count,
  output logic [15:0]         o_stall_count
`endif
);
  localparam int OW = $clog2(EXPANSION_FACTOR);
  localparam int RW = $clog2(NUM_RAMS);
  localparam int c_LANES = 8;
  localparam logic [OW-1:0] c_ZM1 = OW'(EXPANSION_FACTOR - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [OW-1:0]      r_beat;
  logic [8*RW-1:0]    r_ram;
  logic [8*RW-1:0]    r_ram_addr;
  logic [8*3-1:0]     r_branch;
  logic [8*3-1:0]     r_to_branch;
  logic [8*WIDTH-1:0] r_data;
  logic               r_valid;
  logic               r_done;
  logic               r_err;
  logic [c_LANES-1:0] w_bad;
  logic               w_desc_acc;
  logic               w_load;
  logic               w_beat_acc;
  logic               w_last;
  logic               w_desc_ready;
  logic               w_data_ready;
  logic               w_busy;

  assign w_desc_acc = (r_state == S_IDLE) && bus.i_desc_valid;
  assign w_load     = w_desc_acc && (w_bad == '0);
  assign w_beat_acc = (r_state == S_RUN) && bus.i_data_valid;
  assign w_last     = w_beat_acc && (r_beat == c_ZM1);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_desc_ready = 1'b0;
    w_data_ready = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE:  w_desc_ready = 1'b1;
      S_RUN: begin
        w_data_ready = 1'b1;
        w_busy       = 1'b1;
      end
      default: ;
    endcase
  end

  // Each lane walks (shift + beat) mod Z with a compare-and-wrap counter.
  for (genvar n = 0; n < c_LANES; n++) begin : g_lane
    logic [OW-1:0] w_shift;
    logic [OW-1:0] r_cnt;
    logic [OW-1:0] r_off;

    assign w_shift  = bus.i_desc_shift[n*OW +: OW];
    assign w_bad[n] = (w_shift > c_ZM1);

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        r_cnt <= '0;
        r_off <= '0;
      end else if (w_load) begin
        r_cnt <= w_shift;
      end else if (w_beat_acc) begin
        r_off <= r_cnt;
        r_cnt <= (r_cnt == c_ZM1) ? '0 : r_cnt + 1'b1;
      end
    end

    assign bus.o_offset[n*OW +: OW] = r_off;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_beat      <= '0;
      r_ram       <= '0;
      r_branch    <= '0;
      r_data      <= '0;
      r_ram_addr  <= '0;
      r_to_branch <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_valid <= w_beat_acc;
      r_done  <= (r_state == S_DONE);
      r_err   <= w_desc_acc && (w_bad != '0);
      if (w_load) begin
        r_beat   <= '0;
        r_ram    <= bus.i_desc_ram;
        r_branch <= bus.i_desc_branch;
      end else if (w_beat_acc) begin
        r_beat      <= r_beat + 1'b1;
        r_data      <= bus.i_data;
        r_ram_addr  <= r_ram;
        r_to_branch <= r_branch;
      end
    end
  end

  assign bus.o_desc_ready = w_desc_ready;
  assign bus.o_data_ready = w_data_ready;
  assign bus.o_busy       = w_busy;
  assign bus.o_data       = r_data;
  assign bus.o_ram_addr   = r_ram_addr;
  assign bus.o_to_branch  = r_to_branch;
  assign bus.o_valid      = r_valid;
  assign bus.o_done       = r_done;
  assign bus.o_desc_error = r_err;

`ifdef LDPC_MUX_SCHEDULER_STATS_EN
  logic [15:0] r_layer_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_layer_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (r_done && (r_layer_count != 16'hFFFF))
        r_layer_count <= r_layer_count + 1'b1;
      if ((r_state == S_RUN) && !bus.i_data_valid && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign o_layer_count = r_layer_count;
  assign o_stall_count = r_stall_count;
`endif
endmodule
`default_nettype wire
